// File: rtl/wb_intercon_1to3_if.sv
// rtl/wb_intercon_1to3_if.sv - bus bundle between the master port, the interconnect and its three slaves
interface wb_intercon_1to3_if;
   logic [31:0] m_adr_i;
   logic [31:0] m_dat_i;
   logic [3:0]  m_sel_i;
   logic        m_we_i;
   logic        m_cyc_i;
   logic        m_stb_i;
   logic [31:0] m_dat_o;
   logic        m_ack_o;
   logic        m_err_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o;
   logic [2:0]  s_cyc_o;
   logic [2:0]  s_stb_o;
   logic [95:0] s_dat_i;
   logic [2:0]  s_ack_i;
   logic [7:0]  err_cnt;

   // the interconnect itself
   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o,
             s_cyc_o, s_stb_o, err_cnt
   );

   // the surrounding CPU master and slave devices
   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o,
             s_cyc_o, s_stb_o, err_cnt
   );
endinterface

// File: rtl/wb_intercon_1to3.sv
// rtl/wb_intercon_1to3.sv - registered Wishbone classic 1-master/3-slave interconnect with ack watchdog
module wb_intercon_1to3 #(
   parameter logic [31:0] S1_BASE        = 32'h3000_0000,
   parameter logic [31:0] S1_SIZE        = 32'h0000_000C,
   parameter logic [31:0] S2_BASE        = 32'h4000_0000,
   parameter logic [31:0] S2_SIZE        = 32'h0000_000C,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   wb_intercon_1to3_if.slave bus
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] m_dat_q, m_dat_d;
   logic        m_ack_q, m_ack_d;
   logic        m_err_q, m_err_d;
   logic [31:0] s_adr_q, s_adr_d;
   logic [31:0] s_dat_q, s_dat_d;
   logic [3:0]  s_sel_q, s_sel_d;
   logic        s_we_q, s_we_d;
   logic [2:0]  s_cyc_q, s_cyc_d;
   logic [2:0]  s_stb_q, s_stb_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic [32:0] adr_x;
   logic        hit1, hit2;
   logic [1:0]  dec_sel;
   logic        ack_sel;
   logic [31:0] rd_sel;

   // 33-bit compares keep base+size from wrapping at the top of the map
   always_comb begin
      adr_x   = {1'b0, bus.m_adr_i};
      hit1    = (adr_x >= {1'b0, S1_BASE}) && (adr_x < ({1'b0, S1_BASE} + {1'b0, S1_SIZE}));
      hit2    = (adr_x >= {1'b0, S2_BASE}) && (adr_x < ({1'b0, S2_BASE} + {1'b0, S2_SIZE}));
      dec_sel = 2'd0;
      if (hit1)      dec_sel = 2'd1;
      else if (hit2) dec_sel = 2'd2;
   end

   always_comb begin
      ack_sel = bus.s_ack_i[0];
      rd_sel  = bus.s_dat_i[31:0];
      case (sel_q)
         2'd1: begin
            ack_sel = bus.s_ack_i[1];
            rd_sel  = bus.s_dat_i[63:32];
         end
         2'd2: begin
            ack_sel = bus.s_ack_i[2];
            rd_sel  = bus.s_dat_i[95:64];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      m_dat_d   = m_dat_q;
      m_ack_d   = 1'b0;
      m_err_d   = 1'b0;
      s_adr_d   = s_adr_q;
      s_dat_d   = s_dat_q;
      s_sel_d   = s_sel_q;
      s_we_d    = s_we_q;
      s_cyc_d   = s_cyc_q;
      s_stb_d   = s_stb_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.m_cyc_i && bus.m_stb_i) begin
               s_adr_d = bus.m_adr_i;
               s_dat_d = bus.m_dat_i;
               s_sel_d = bus.m_sel_i;
               s_we_d  = bus.m_we_i;
               sel_d   = dec_sel;
               s_cyc_d = 3'b001 << dec_sel;
               s_stb_d = 3'b001 << dec_sel;
               cnt_d   = 8'd0;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!bus.m_cyc_i) begin
               s_cyc_d = 3'b000;
               s_stb_d = 3'b000;
               state_d = IDLE;
            end else if (ack_sel) begin
               m_dat_d = rd_sel;
               m_ack_d = 1'b1;
               s_cyc_d = 3'b000;
               s_stb_d = 3'b000;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               m_dat_d = ERR_DATA;
               m_ack_d = 1'b1;
               m_err_d = 1'b1;
               s_cyc_d = 3'b000;
               s_stb_d = 3'b000;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         cnt_q     <= 8'd0;
         m_dat_q   <= 32'd0;
         m_ack_q   <= 1'b0;
         m_err_q   <= 1'b0;
         s_adr_q   <= 32'd0;
         s_dat_q   <= 32'd0;
         s_sel_q   <= 4'd0;
         s_we_q    <= 1'b0;
         s_cyc_q   <= 3'd0;
         s_stb_q   <= 3'd0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         m_dat_q   <= m_dat_d;
         m_ack_q   <= m_ack_d;
         m_err_q   <= m_err_d;
         s_adr_q   <= s_adr_d;
         s_dat_q   <= s_dat_d;
         s_sel_q   <= s_sel_d;
         s_we_q    <= s_we_d;
         s_cyc_q   <= s_cyc_d;
         s_stb_q   <= s_stb_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.m_dat_o = m_dat_q;
   assign bus.m_ack_o = m_ack_q;
   assign bus.m_err_o = m_err_q;
   assign bus.s_adr_o = s_adr_q;
   assign bus.s_dat_o = s_dat_q;
   assign bus.s_sel_o = s_sel_q;
   assign bus.s_we_o  = s_we_q;
   assign bus.s_cyc_o = s_cyc_q;
   assign bus.s_stb_o = s_stb_q;
   assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_wb_intercon_1to3.sv
// tb/tb_wb_intercon_1to3.sv - directed scoreboard bench for wb_intercon_1to3
module tb_wb_intercon_1to3;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_intercon_1to3_if bus ();
   wb_intercon_1to3_if bus2 ();

   wb_intercon_1to3 #(.TIMEOUT_CYCLES(TMO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   // second instance with slave 2 window placed on top of slave 1
   wb_intercon_1to3 #(.S2_BASE(32'h3000_0000), .S2_SIZE(32'h0000_000C)) dut_ovl (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus2)
   );

   typedef struct packed {
      logic [31:0] dat;
      logic        err;
   } resp_t;

   resp_t sb[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    exp_err_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // lat = cycles from strobe visible to slave ack; negative means the slave never acks
   task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input int slv, input int lat, input logic [31:0] rdata);
      resp_t      e;
      resp_t      got;
      logic [2:0] oh;
      int         exp_cyc;
      int         cyc;
      bit         seen;
      oh      = 3'b001 << slv;
      e.err   = (lat < 0) || (lat > TMO - 1);
      e.dat   = e.err ? 32'hDEAD_BEEF : rdata;
      exp_cyc = e.err ? TMO + 1 : lat + 2;
      if (e.err) exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
      sb.push_back(e);
      bus.m_adr_i = adr;
      bus.m_dat_i = dat;
      bus.m_sel_i = sel;
      bus.m_we_i  = we;
      bus.m_cyc_i = 1'b1;
      bus.m_stb_i = 1'b1;
      tick();
      chk("s_stb_route", bus.s_stb_o, oh);
      chk("s_cyc_route", bus.s_cyc_o, oh);
      chk("s_adr", bus.s_adr_o, adr);
      chk("s_dat", bus.s_dat_o, dat);
      chk("s_sel", bus.s_sel_o, sel);
      chk("s_we", bus.s_we_o, we);
      seen = 0;
      cyc  = 1;
      while (!seen && cyc <= 40) begin
         bus.s_dat_i = {3{~rdata}};
         bus.s_dat_i[slv*32 +: 32] = rdata;
         if (cyc == lat + 1) bus.s_ack_i = oh;
         else                bus.s_ack_i = (lat < 0) ? ~oh : 3'b000;
         tick();
         cyc++;
         if (bus.m_ack_o === 1'b1) seen = 1;
      end
      bus.s_ack_i = 3'b000;
      chk("ack_seen", seen, 1);
      if (seen) begin
         got = sb.pop_front();
         chk("ack_cycle", cyc, exp_cyc);
         chk("m_dat", bus.m_dat_o, got.dat);
         chk("m_err", bus.m_err_o, got.err);
         chk("s_stb_clr", bus.s_stb_o, 3'b000);
         chk("err_cnt", bus.err_cnt, exp_err_cnt);
      end else begin
         sb.delete();
      end
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
      tick();
      chk("ack_pulse", bus.m_ack_o, 0);
      chk("err_pulse", bus.m_err_o, 0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.m_adr_i  = 32'd0;
      bus.m_dat_i  = 32'd0;
      bus.m_sel_i  = 4'd0;
      bus.m_we_i   = 1'b0;
      bus.m_cyc_i  = 1'b0;
      bus.m_stb_i  = 1'b0;
      bus.s_dat_i  = 96'd0;
      bus.s_ack_i  = 3'd0;
      bus2.m_adr_i = 32'd0;
      bus2.m_dat_i = 32'd0;
      bus2.m_sel_i = 4'd0;
      bus2.m_we_i  = 1'b0;
      bus2.m_cyc_i = 1'b0;
      bus2.m_stb_i = 1'b0;
      bus2.s_dat_i = 96'd0;
      bus2.s_ack_i = 3'd0;
      repeat (3) tick();

      chk("rst_m_dat", bus.m_dat_o, 0);
      chk("rst_m_ack", bus.m_ack_o, 0);
      chk("rst_m_err", bus.m_err_o, 0);
      chk("rst_s_cyc", bus.s_cyc_o, 0);
      chk("rst_s_stb", bus.s_stb_o, 0);
      chk("rst_s_adr", bus.s_adr_o, 0);
      chk("rst_err_cnt", bus.err_cnt, 0);
      rst = 1'b0;
      tick();

      txn(32'h0000_0100, 32'h0, 4'b1111, 1'b0, 0, 1, 32'h1234_5678);
      txn(32'h3000_0004, 32'hA5A5_0001, 4'b1111, 1'b1, 1, 0, 32'h0);
      txn(32'h3000_0000, 32'h1111_2222, 4'b0011, 1'b1, 1, 2, 32'h0BAD_0001);
      txn(32'h3000_000C, 32'h0, 4'b1100, 1'b0, 0, 0, 32'hCAFE_0000);
      txn(32'h4000_0008, 32'h0, 4'b0001, 1'b0, 2, 3, 32'h0000_4008);
      txn(32'h4000_000C, 32'h0, 4'b1111, 1'b0, 0, 1, 32'h0000_400C);
      txn(32'h2FFF_FFFC, 32'h0, 4'b1000, 1'b0, 0, 0, 32'h2FFF_FFFC);

      txn(32'h4000_0000, 32'h0, 4'b1111, 1'b0, 2, -1, 32'h5555_AAAA);
      txn(32'h4000_0004, 32'h0, 4'b1111, 1'b0, 2, TMO - 1, 32'h7777_8888);

      // master abort mid-transfer, followed by a late ack that must be ignored
      bus.m_adr_i = 32'h3000_0008;
      bus.m_cyc_i = 1'b1;
      bus.m_stb_i = 1'b1;
      tick();
      chk("abort_route", bus.s_stb_o, 3'b010);
      tick();
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
      tick();
      chk("abort_s_cyc", bus.s_cyc_o, 0);
      chk("abort_s_stb", bus.s_stb_o, 0);
      chk("abort_ack", bus.m_ack_o, 0);
      bus.s_ack_i = 3'b010;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_ack", bus.m_ack_o, 0);
      end
      bus.s_ack_i = 3'b000;
      tick();

      // reset in the middle of an ACTIVE transfer
      bus.m_adr_i = 32'h4000_0000;
      bus.m_cyc_i = 1'b1;
      bus.m_stb_i = 1'b1;
      repeat (3) tick();
      chk("pre_rst_stb", bus.s_stb_o, 3'b100);
      rst = 1'b1;
      tick();
      exp_err_cnt = 0;
      chk("mid_rst_s_cyc", bus.s_cyc_o, 0);
      chk("mid_rst_s_stb", bus.s_stb_o, 0);
      chk("mid_rst_m_ack", bus.m_ack_o, 0);
      chk("mid_rst_s_adr", bus.s_adr_o, 0);
      chk("mid_rst_err_cnt", bus.err_cnt, 0);
      rst = 1'b0;
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
      bus.s_ack_i = 3'b100;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("late_ack_ignored", bus.m_ack_o, 0);
      end
      bus.s_ack_i = 3'b000;
      tick();
      txn(32'h4000_0004, 32'h0, 4'b1111, 1'b0, 2, 1, 32'h0123_4567);

      bus2.m_adr_i = 32'h3000_0004;
      bus2.m_cyc_i = 1'b1;
      bus2.m_stb_i = 1'b1;
      tick();
      chk("overlap_route", bus2.s_stb_o, 3'b010);
      bus2.m_cyc_i = 1'b0;
      bus2.m_stb_i = 1'b0;
      tick();
      chk("overlap_abort", bus2.s_cyc_o, 0);

      for (int i = 0; i < 257; i++) begin
         txn(32'h4000_0000, 32'h0, 4'b1111, 1'b0, 2, -1, 32'h0);
      end
      chk("err_cnt_sat", bus.err_cnt, 8'd255);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
